// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Fetch looks it up combinationally with the current PC; the
// branch-resolve stage updates it with each resolved branch and gets a
// mispredict/redirect request back.
//
// Parameters:
//   ENTRIES  number of table entries (power of two, >= 2)
//   ADDR_W   PC / target width
//   CNT_W    direction counter width (>= 1)
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   pc_in             fetch PC to look up
//   pred_hit          valid entry with matching tag
//   pred_taken        hit and counter MSB set
//   pred_target       stored target when predicted taken, else pc_in+4
//   bp_clear          synchronous invalidate-all (wins over same-cycle update)
//   upd_valid         resolved branch present this cycle
//   upd_pc            PC of the resolved branch
//   upd_taken         actual direction
//   upd_target        actual taken target
//   upd_pred_taken    prediction carried down the pipe
//   upd_pred_target   predicted next PC carried down the pipe
//   mispredict        redirect/flush request (combinational)
//   redirect_pc       correct next PC (meaningful only when mispredict=1)
//
// Optional feature, enabled by defining BP_STATS_EN:
//   stat_branches     saturating count of cycles with upd_valid
//   stat_mispredicts  saturating count of cycles with mispredict
//   stat_hits         saturating count of cycles with upd_valid and a table hit
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              bp_clear,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts,
    output logic [31:0]       stat_hits
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // Newly allocated entries start weakly taken.
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    // Table storage. Only the valid bits are reset; tag/target/cnt are
    // masked by valid=0 and therefore need no reset.
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CNT_W-1:0]   r_cnt    [ENTRIES];

    // ---------------------------------------------------------------------
    // Lookup (combinational, stored state only, no bypass from update)
    // ---------------------------------------------------------------------
    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic              w_lk_hit;
    logic              w_lk_taken;
    logic [ADDR_W-1:0] w_lk_seq;

    assign w_lk_idx   = pc_in[IDX_W+1:2];
    assign w_lk_tag   = pc_in[ADDR_W-1:IDX_W+2];
    assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && r_cnt[w_lk_idx][CNT_W-1];
    assign w_lk_seq   = pc_in + ADDR_W'(4);

    assign pred_hit    = w_lk_hit;
    assign pred_taken  = w_lk_taken;
    assign pred_target = w_lk_taken ? r_target[w_lk_idx] : w_lk_seq;

    // ---------------------------------------------------------------------
    // Resolve side: mispredict detection and redirect
    // ---------------------------------------------------------------------
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_write;
    logic             w_up_alloc;
    logic [CNT_W-1:0] w_up_cnt_nxt;

    assign w_up_idx = upd_pc[IDX_W+1:2];
    assign w_up_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    assign mispredict  = upd_valid &&
                         ((upd_pred_taken != upd_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = upd_taken ? upd_target : (upd_pc + ADDR_W'(4));

    // bp_clear suppresses the whole table write, not just the valid bit.
    assign w_up_write = upd_valid && !bp_clear;
    assign w_up_alloc = w_up_write && upd_taken && !w_up_hit;

    // Saturating counter step for the entry being updated.
    always_comb begin
        w_up_cnt_nxt = r_cnt[w_up_idx];
        if (upd_taken) begin
            if (r_cnt[w_up_idx] != CNT_MAX) begin
                w_up_cnt_nxt = r_cnt[w_up_idx] + CNT_W'(1);
            end
        end else if (r_cnt[w_up_idx] != '0) begin
            w_up_cnt_nxt = r_cnt[w_up_idx] - CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Table state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (bp_clear) begin
            r_valid <= '0;
        end else if (w_up_alloc) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_up_write && w_up_hit) begin
            r_cnt[w_up_idx] <= w_up_cnt_nxt;
            if (upd_taken) begin
                r_target[w_up_idx] <= upd_target;
            end
        end else if (w_up_alloc) begin
            // Direct-mapped: a taken miss simply replaces whatever is there.
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target;
            r_cnt[w_up_idx]    <= CNT_WEAK;
        end
    end

`ifdef BP_STATS_EN
    // ---------------------------------------------------------------------
    // Statistics counters (saturating, untouched by bp_clear)
    // ---------------------------------------------------------------------
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;
    logic [31:0] r_stat_hits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
            r_stat_hits        <= '0;
        end else begin
            if (upd_valid && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
            if (upd_valid && w_up_hit && (r_stat_hits != 32'hFFFF_FFFF)) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
    assign stat_hits        = r_stat_hits;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int unsigned ENTRIES = 16;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned IDX_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] pc_in;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              bp_clear;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispredicts;
    logic [31:0]       stat_hits;
`endif

    branch_predictor #(
        .ENTRIES(ENTRIES),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .bp_clear       (bp_clear),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts),
        .stat_hits       (stat_hits)
`endif
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model: one record per table slot, plus stats tallies.
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    int unsigned ms_br  = 0;
    int unsigned ms_mis = 0;
    int unsigned ms_hit = 0;

    logic [31:0] r_upc, r_utgt, r_uptgt, r_pc;
    logic        r_ut, r_upt, r_uv, r_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int f_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] f_tag(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit f_hit(input logic [31:0] pc);
        return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
    endfunction

    function automatic bit f_taken(input logic [31:0] pc);
        return f_hit(pc) && (m_cnt[f_idx(pc)] >= (1 << (CNT_W - 1)));
    endfunction

    function automatic logic [31:0] f_target(input logic [31:0] pc);
        return f_taken(pc) ? m_target[f_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit f_mis();
        return upd_valid && ((upd_pred_taken != upd_taken) ||
                             (upd_taken && (upd_pred_target != upd_target)));
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    function automatic logic [31:0] rnd_pc();
        logic [31:0] low2 = 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC | low2;
        return (32'($urandom_range(0, 47)) << 2) | low2;
    endfunction

    // Apply the resolved branch in the model (state before this edge).
    task automatic m_update();
        bit h;
        int i;
        h = f_hit(upd_pc);
        i = f_idx(upd_pc);
        if (upd_valid) begin
            ms_br = sat_inc(ms_br);
            if (h) ms_hit = sat_inc(ms_hit);
        end
        if (f_mis()) ms_mis = sat_inc(ms_mis);
        if (bp_clear) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (upd_valid) begin
            if (h) begin
                if (upd_taken) begin
                    if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i] = m_cnt[i] + 1;
                    m_target[i] = upd_target;
                end else if (m_cnt[i] > 0) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end else if (upd_taken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = f_tag(upd_pc);
                m_target[i] = upd_target;
                m_cnt[i]    = 1 << (CNT_W - 1);
            end
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        ms_br  = 0;
        ms_mis = 0;
        ms_hit = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic upt,
                         input logic [31:0] uptgt, input logic clr);
        pc_in           = pc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        bp_clear        = clr;
    endtask

    task automatic look(input logic [31:0] pc);
        drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Compare every output against the model, away from the active edge.
    task automatic check_model(input string tag);
        @(negedge clk);
        chk({tag, ".hit"},    32'(pred_hit),    32'(f_hit(pc_in)));
        chk({tag, ".taken"},  32'(pred_taken),  32'(f_taken(pc_in)));
        chk({tag, ".target"}, pred_target,      f_target(pc_in));
        chk({tag, ".mis"},    32'(mispredict),  32'(f_mis()));
        if (f_mis()) begin
            chk({tag, ".redir"}, redirect_pc,
                upd_taken ? upd_target : upd_pc + 32'd4);
        end
`ifdef BP_STATS_EN
        chk({tag, ".st_br"},  stat_branches,    ms_br);
        chk({tag, ".st_mis"}, stat_mispredicts, ms_mis);
        chk({tag, ".st_hit"}, stat_hits,        ms_hit);
`endif
    endtask

    task automatic tick();
        m_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset phase
        rst = 1'b1;
        look(32'h40);
        #2;
        chk("rst.hit",    32'(pred_hit),   32'd0);
        chk("rst.taken",  32'(pred_taken), 32'd0);
        chk("rst.target", pred_target,     32'h44);
        chk("rst.mis",    32'(mispredict), 32'd0);
        m_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // First allocation while looking up the same PC
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
        check_model("alloc");
        chk("alloc.hit0",  32'(pred_hit),   32'd0);
        chk("alloc.tgt0",  pred_target,     32'h44);
        chk("alloc.mis",   32'(mispredict), 32'd1);
        chk("alloc.redir", redirect_pc,     32'h100);
        tick();
        look(32'h40);
        check_model("alloc_next");
        chk("alloc_next.hit",   32'(pred_hit),   32'd1);
        chk("alloc_next.taken", 32'(pred_taken), 32'd1);
        chk("alloc_next.tgt",   pred_target,     32'h100);
        tick();

        // Saturation at zero: three not-taken updates (cnt 2 -> 1 -> 0 -> 0)
        for (int k = 0; k < 3; k++) begin
            drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h300, 1'(k == 0),
                  (k == 0) ? 32'h100 : 32'h44, 1'b0);
            check_model("sat_dn");
            if (k > 0) begin
                chk("sat_dn.hit",   32'(pred_hit),   32'd1);
                chk("sat_dn.taken", 32'(pred_taken), 32'd0);
                chk("sat_dn.tgt",   pred_target,     32'h44);
            end
            tick();
        end
        // One taken step from saturated zero must still predict not-taken
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
        check_model("sat_up1");
        tick();
        look(32'h40);
        check_model("sat_up1_look");
        chk("sat_up1.taken", 32'(pred_taken), 32'd0);
        chk("sat_up1.hit",   32'(pred_hit),   32'd1);
        tick();
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
        check_model("sat_up2");
        tick();

        // Target change on a hit
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h180, 1'b1, 32'h100, 1'b0);
        check_model("tchg");
        chk("tchg.mis",   32'(mispredict), 32'd1);
        chk("tchg.redir", redirect_pc,     32'h180);
        tick();
        look(32'h40);
        check_model("tchg_look");
        chk("tchg_look.tgt", pred_target, 32'h180);
        tick();

        // Aliasing at index 0: 0x80 replaces 0x40
        drive(32'h40, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84, 1'b0);
        check_model("alias_alloc");
        tick();
        look(32'h40);
        check_model("alias_40");
        chk("alias_40.hit", 32'(pred_hit), 32'd0);
        chk("alias_40.tgt", pred_target,   32'h44);
        tick();
        drive(32'h80, 1'b1, 32'hC0, 1'b0, 32'h0, 1'b0, 32'hC4, 1'b0);
        check_model("alias_nt_miss");
        chk("alias_nt_miss.mis", 32'(mispredict), 32'd0);
        tick();
        look(32'h80);
        check_model("alias_80");
        chk("alias_80.taken", 32'(pred_taken), 32'd1);
        chk("alias_80.tgt",   pred_target,     32'h200);
        tick();

        // Same-cycle lookup/update of one index: no bypass
        drive(32'h44, 1'b1, 32'h44, 1'b1, 32'h500, 1'b0, 32'h48, 1'b0);
        check_model("nobyp");
        chk("nobyp.hit", 32'(pred_hit), 32'd0);
        tick();
        look(32'h44);
        check_model("nobyp_next");
        chk("nobyp_next.hit", 32'(pred_hit), 32'd1);
        tick();

        // Clear together with a taken update
        drive(32'h48, 1'b1, 32'h48, 1'b1, 32'h600, 1'b0, 32'h4C, 1'b1);
        check_model("clr");
        tick();
        look(32'h48);
        check_model("clr_48");
        chk("clr_48.hit", 32'(pred_hit), 32'd0);
        tick();
        look(32'h80);
        check_model("clr_80");
        chk("clr_80.hit", 32'(pred_hit), 32'd0);
        chk("clr_80.tgt", pred_target,   32'h84);
        tick();

        // PC+4 wrap on both sides
        drive(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
        check_model("wrap");
        chk("wrap.tgt",   pred_target, 32'h0);
        chk("wrap.redir", redirect_pc, 32'h0);
        tick();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            r_upc  = rnd_pc();
            r_ut   = 1'($urandom_range(0, 1));
            r_utgt = rnd_pc();
            if ($urandom_range(0, 4) != 0) begin
                r_upt   = f_taken(r_upc);
                r_uptgt = f_target(r_upc);
            end else begin
                r_upt   = 1'($urandom_range(0, 1));
                r_uptgt = ($urandom_range(0, 1) != 0) ? r_utgt : r_upc + 32'd4;
            end
            r_uv  = 1'($urandom_range(0, 3) != 0);
            r_clr = 1'($urandom_range(0, 39) == 0);
            r_pc  = ($urandom_range(0, 1) != 0) ? r_upc : rnd_pc();
            drive(r_pc, r_uv, r_upc, r_ut, r_utgt, r_upt, r_uptgt, r_clr);
            check_model("rnd");
            tick();
        end

        // Asynchronous reset mid-stream
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
        check_model("mr_alloc");
        tick();
        look(32'h40);
        #2;
        chk("mr_pre.hit", 32'(pred_hit), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr.hit",   32'(pred_hit),   32'd0);
        chk("mr.taken", 32'(pred_taken), 32'd0);
        chk("mr.tgt",   pred_target,     32'h44);
        m_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        look(32'h40);
        check_model("mr_after");

`ifdef BP_STATS_EN
        chk("st0.br", stat_branches, 32'd0);
        tick();
        // 5 updates, 2 mispredicted, 3 hits
        drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
        check_model("st1");
        tick();
        drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
        check_model("st2");
        tick();
        drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b0);
        check_model("st3");
        tick();
        drive(32'h0, 1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44, 1'b0);
        check_model("st4");
        tick();
        drive(32'h0, 1'b1, 32'h84, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
        check_model("st5");
        tick();
        drive(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check_model("st_clr");
        chk("st.br",  stat_branches,    32'd5);
        chk("st.mis", stat_mispredicts, 32'd2);
        chk("st.hit", stat_hits,        32'd3);
        tick();
        look(32'h40);
        check_model("st_after_clr");
        chk("st_clr.br",  stat_branches,    32'd5);
        chk("st_clr.mis", stat_mispredicts, 32'd2);
        chk("st_clr.hit", stat_hits,        32'd3);
        rst = 1'b1;
        #1;
        chk("st_rst.br",  stat_branches,    32'd0);
        chk("st_rst.mis", stat_mispredicts, 32'd0);
        chk("st_rst.hit", stat_hits,        32'd0);
        m_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
